// File: rtl/nibble_serial_adder_ctrl.sv
// Serial 10-bit signed add/sub built from one 4-bit adder slice.
// Operands are sign-extended to 12 bits and processed one nibble per cycle.
module nibble_serial_adder_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_sub,
  input  logic [9:0] A,
  input  logic [9:0] B,
  output logic       busy,
  output logic       done,
  output logic [9:0] Sum,
  output logic       Overflow
);

  typedef enum logic [2:0] {
    IDLE,
    NIB0,
    NIB1,
    NIB2,
    DONE
  } state_t;

  state_t      state;
  logic [11:0] opa;
  logic [11:0] opb;
  logic        carry;
  logic [7:0]  work;

  logic [3:0]  mux_a;
  logic [3:0]  mux_b;
  logic [3:0]  slice_sum;
  logic        slice_cout;

  always_comb begin
    mux_a = 4'd0;
    mux_b = 4'd0;
    case (state)
      NIB0: begin
        mux_a = opa[3:0];
        mux_b = opb[3:0];
      end
      NIB1: begin
        mux_a = opa[7:4];
        mux_b = opb[7:4];
      end
      NIB2: begin
        mux_a = opa[11:8];
        mux_b = opb[11:8];
      end
      default: ;
    endcase
  end

  // the single shared 4-bit adder slice
  assign {slice_cout, slice_sum} =
    {1'b0, mux_a} + {1'b0, mux_b} + {4'd0, carry};

  // res[10] always equals res[11] for sign-extended 10-bit inputs
  logic unused_res10;
  assign unused_res10 = slice_sum[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= 12'd0;
      opb      <= 12'd0;
      carry    <= 1'b0;
      work     <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= 10'd0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= {{2{A[9]}}, A};
            opb   <= op_sub ? ~{{2{B[9]}}, B}
                            :  {{2{B[9]}}, B};
            carry <= op_sub;
            busy  <= 1'b1;
            state <= NIB0;
          end
        end
        NIB0: begin
          work[3:0] <= slice_sum;
          carry     <= slice_cout;
          state     <= NIB1;
        end
        NIB1: begin
          work[7:4] <= slice_sum;
          carry     <= slice_cout;
          state     <= NIB2;
        end
        NIB2: begin
          Sum      <= {slice_sum[1:0], work};
          Overflow <= slice_sum[3] ^ slice_sum[1];
          carry    <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
